// File: rtl/apbdma_downsizer_arbiter_pkg.sv
// Shared types and helpers for the APB DMA downsizer arbiter and its scheduler siblings.
package apbdma_pkg;

    typedef enum logic {
        Idle   = 1'b0,
        Locked = 1'b1
    } arb_state_t;

    // A single channel still needs a 1-bit index, so never let the width collapse to 0.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apbdma_downsizer_arbiter_if.sv
// Channel-side and downsizer-side signals of the arbiter, bundled with directional modports.
// Handshake: a beat transfers on a cycle where valid and ready are both high; valid never
// waits for ready, and data/strb/last stay stable from valid rising until that transfer.
interface apbdma_downsizer_arbiter_if #(
    parameter int NumChannels = 4,
    parameter int DataWidth   = 64,
    parameter int IdWidth     = 2
);
    logic [NumChannels-1:0]                  ch_en_i;
    logic [NumChannels-1:0][DataWidth-1:0]   ch_data_i;
    logic [NumChannels-1:0][DataWidth/8-1:0] ch_strb_i;
    logic [NumChannels-1:0]                  ch_last_i;
    logic [NumChannels-1:0]                  ch_valid_i;
    logic [NumChannels-1:0]                  ch_ready_o;
    logic [DataWidth-1:0]                    data_o;
    logic [DataWidth/8-1:0]                  strb_o;
    logic                                    last_o;
    logic [IdWidth-1:0]                      id_o;
    logic                                    valid_o;
    logic                                    ready_i;
    logic                                    busy_o;

    modport slave (
        input  ch_en_i, ch_data_i, ch_strb_i, ch_last_i, ch_valid_i, ready_i,
        output ch_ready_o, data_o, strb_o, last_o, id_o, valid_o, busy_o
    );

    modport master (
        output ch_en_i, ch_data_i, ch_strb_i, ch_last_i, ch_valid_i, ready_i,
        input  ch_ready_o, data_o, strb_o, last_o, id_o, valid_o, busy_o
    );
endinterface

// File: rtl/apbdma_downsizer_arbiter_rr_pick.sv
// Combinational round-robin picker: first set candidate at or after ptr_i, wrapping.
module apbdma_rr_pick #(
    parameter int NumChannels = 4,
    parameter int IdWidth     = 2
) (
    input  logic [NumChannels-1:0] cand_i,
    input  logic [IdWidth-1:0]     ptr_i,
    output logic [IdWidth-1:0]     winner_o,
    output logic                   any_o
);

    logic [NumChannels-1:0] rot;
    logic                   found;
    int                     off;
    int                     win;

    // Rotate so ptr_i lands at bit 0, priority-encode, then rotate the index back.
    always_comb begin
        rot   = '0;
        found = 1'b0;
        off   = 0;
        win   = 0;
        for (int i = 0; i < NumChannels; i++) begin
            rot[i] = cand_i[(i + int'(ptr_i)) % NumChannels];
        end
        for (int i = 0; i < NumChannels; i++) begin
            if (rot[i] && !found) begin
                found = 1'b1;
                off   = i;
            end
        end
        win      = (off + int'(ptr_i)) % NumChannels;
        winner_o = IdWidth'(win);
        any_o    = |cand_i;
    end

endmodule

// File: rtl/apbdma_downsizer_arbiter.sv
// Burst-locked round-robin arbiter sharing one wide-to-narrow downsizer between DMA channels.
module apbdma_downsizer_arbiter
    import apbdma_pkg::*;
#(
    parameter int  NumChannels = 4,
    parameter int  DataWidth   = 64,
    parameter int  MaxHold     = 16,
    localparam int IdWidth     = id_width(NumChannels)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    apbdma_downsizer_arbiter_if.slave   bus,
    output arb_state_t                  state_o,
    output logic [IdWidth-1:0]          rr_ptr_o
);

    localparam int                 HoldW   = $clog2(MaxHold + 1);
    localparam logic [HoldW-1:0]   HoldEnd = HoldW'(MaxHold - 1);
    localparam logic [IdWidth-1:0] LastCh  = IdWidth'(NumChannels - 1);

    arb_state_t         state_q, state_d;
    logic [IdWidth-1:0] grant_q, grant_d;
    logic [IdWidth-1:0] rr_ptr_q, rr_ptr_d;
    logic [HoldW-1:0]   hold_cnt_q, hold_cnt_d;

    logic [NumChannels-1:0] cand;
    logic [NumChannels-1:0] ch_ready;
    logic [IdWidth-1:0]     winner;
    logic                   any_valid;
    logic                   locked;
    logic                   valid_s;
    logic                   last_s;
    logic                   handshake;

    // Enable only gates entry to arbitration; a held grant runs to last or MaxHold.
    assign cand = bus.ch_valid_i & bus.ch_en_i;

    apbdma_rr_pick #(
        .NumChannels (NumChannels),
        .IdWidth     (IdWidth)
    ) u_rr_pick (
        .cand_i   (cand),
        .ptr_i    (rr_ptr_q),
        .winner_o (winner),
        .any_o    (any_valid)
    );

    assign locked    = (state_q == Locked);
    assign valid_s   = locked & bus.ch_valid_i[grant_q];
    assign last_s    = bus.ch_last_i[grant_q];
    assign handshake = valid_s & bus.ready_i;

    always_comb begin
        ch_ready = '0;
        if (locked) begin
            ch_ready[grant_q] = bus.ready_i;
        end
    end

    assign bus.ch_ready_o = ch_ready;
    assign bus.data_o     = bus.ch_data_i[grant_q];
    assign bus.strb_o     = bus.ch_strb_i[grant_q];
    assign bus.last_o     = last_s;
    assign bus.valid_o    = valid_s;
    assign bus.id_o       = grant_q;
    assign bus.busy_o     = locked;
    assign state_o        = state_q;
    assign rr_ptr_o       = rr_ptr_q;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            Idle: begin
                if (any_valid) begin
                    grant_d    = winner;
                    hold_cnt_d = '0;
                    state_d    = Locked;
                end
            end
            Locked: begin
                if (handshake) begin
                    // A forced release leaves the burst open; the channel re-competes for the rest.
                    if (last_s || (hold_cnt_q == HoldEnd)) begin
                        state_d    = Idle;
                        hold_cnt_d = '0;
                        rr_ptr_d   = (grant_q == LastCh) ? '0 : IdWidth'(grant_q + 1'b1);
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = Idle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= Idle;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

endmodule

// File: tb/tb_apbdma_downsizer_arbiter.sv
// Directed bench for apbdma_downsizer_arbiter: one instance with MaxHold=16, one with MaxHold=4.
module tb_apbdma_downsizer_arbiter;
  import apbdma_pkg::*;

  logic clk = 1'b0;
  logic rst_ni;
  int passed = 0;
  int failed = 0;
  int total = 0;
  int beat;
  int seq [23] = '{-1, 0, 0, 0, 0, -1, 2, 2, 2, 2, -1, 0, 0, 0, 0, -1, 2, 2, 2, 2, -1, 0, 0};

  arb_state_t st_a, st_b;
  logic [1:0] rr_a, rr_b;

  always #5 clk = ~clk;

  apbdma_downsizer_arbiter_if #(.NumChannels(4), .DataWidth(64), .IdWidth(2)) a ();
  apbdma_downsizer_arbiter_if #(.NumChannels(4), .DataWidth(64), .IdWidth(2)) b ();

  apbdma_downsizer_arbiter #(.NumChannels(4), .DataWidth(64), .MaxHold(16)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .bus(a), .state_o(st_a), .rr_ptr_o(rr_a)
  );

  apbdma_downsizer_arbiter #(.NumChannels(4), .DataWidth(64), .MaxHold(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_ni), .bus(b), .state_o(st_b), .rr_ptr_o(rr_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a.ch_en_i = '0; a.ch_valid_i = '0; a.ch_last_i = '0; a.ready_i = 1'b1;
    a.ch_data_i = '0; a.ch_strb_i = '1;
    b.ch_en_i = '0; b.ch_valid_i = '0; b.ch_last_i = '0; b.ready_i = 1'b1;
    b.ch_data_i = '0; b.ch_strb_i = '1;
    rst_ni = 1'b1;
    #1 rst_ni = 1'b0;
    #1;
    chk("rst_valid", 64'(a.valid_o), 64'd0);
    chk("rst_busy", 64'(a.busy_o), 64'd0);
    chk("rst_id", 64'(a.id_o), 64'd0);
    chk("rst_ch_ready", 64'(a.ch_ready_o), 64'd0);
    chk("rst_rr", 64'(rr_a), 64'd0);
    chk("rst_state", 64'(st_a), 64'(Idle));
    repeat (2) @(posedge clk);
    #2 rst_ni = 1'b1;

    // Single channel, three beats
    a.ch_en_i = 4'b0010; a.ch_valid_i = 4'b0010; a.ch_data_i[1] = 64'hA1;
    #1 chk("s1_idle_valid", 64'(a.valid_o), 64'd0);
    tick();
    chk("s1_b1_valid", 64'(a.valid_o), 64'd1);
    chk("s1_b1_id", 64'(a.id_o), 64'd1);
    chk("s1_b1_data", a.data_o, 64'hA1);
    chk("s1_b1_strb", 64'(a.strb_o), 64'hFF);
    chk("s1_b1_ch_ready", 64'(a.ch_ready_o), 64'b0010);
    chk("s1_b1_busy", 64'(a.busy_o), 64'd1);
    tick(); a.ch_data_i[1] = 64'hA2;
    #1 chk("s1_b2_data", a.data_o, 64'hA2);
    chk("s1_b2_id", 64'(a.id_o), 64'd1);
    chk("s1_b2_last", 64'(a.last_o), 64'd0);
    tick(); a.ch_data_i[1] = 64'hA3; a.ch_last_i[1] = 1'b1;
    #1 chk("s1_b3_data", a.data_o, 64'hA3);
    chk("s1_b3_id", 64'(a.id_o), 64'd1);
    chk("s1_b3_last", 64'(a.last_o), 64'd1);
    tick(); a.ch_valid_i = '0; a.ch_last_i = '0;
    #1 chk("s1_end_busy", 64'(a.busy_o), 64'd0);
    chk("s1_end_valid", 64'(a.valid_o), 64'd0);
    chk("s1_end_rr", 64'(rr_a), 64'd2);

    // All four channels, one-beat bursts, from a fresh reset
    rst_ni = 1'b0;
    #1 chk("s2_rst_rr", 64'(rr_a), 64'd0);
    tick(); rst_ni = 1'b1;
    a.ch_en_i = 4'b1111; a.ch_valid_i = 4'b1111; a.ch_last_i = 4'b1111;
    for (int i = 0; i < 4; i++) a.ch_data_i[i] = 64'hB0 + 64'(i);
    #1 chk("s2_idle_valid", 64'(a.valid_o), 64'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      #1 chk("s2_grant_valid", 64'(a.valid_o), 64'd1);
      chk("s2_grant_id", 64'(a.id_o), 64'(k % 4));
      chk("s2_grant_data", a.data_o, 64'hB0 + 64'(k % 4));
      tick();
      if (k == 4) a.ch_valid_i = '0;
      #1 chk("s2_gap_valid", 64'(a.valid_o), 64'd0);
      chk("s2_gap_busy", 64'(a.busy_o), 64'd0);
    end
    a.ch_last_i = '0;
    tick();
    chk("s2_rr_after", 64'(rr_a), 64'd1);

    // Backpressure on a ch3 burst: ready 1,0,0,1
    a.ch_valid_i = 4'b1000; a.ch_data_i[3] = 64'hD0;
    #1;
    tick();
    chk("s4_r1_ch_ready", 64'(a.ch_ready_o), 64'b1000);
    chk("s4_r1_data", a.data_o, 64'hD0);
    tick(); a.ch_data_i[3] = 64'hD1; a.ch_last_i[3] = 1'b1; a.ready_i = 1'b0;
    #1 chk("s4_r0a_ch_ready", 64'(a.ch_ready_o), 64'b0000);
    chk("s4_r0a_valid", 64'(a.valid_o), 64'd1);
    chk("s4_r0a_data", a.data_o, 64'hD1);
    tick();
    chk("s4_r0b_ch_ready", 64'(a.ch_ready_o), 64'b0000);
    chk("s4_r0b_data", a.data_o, 64'hD1);
    chk("s4_r0b_state", 64'(st_a), 64'(Locked));
    tick(); a.ready_i = 1'b1;
    #1 chk("s4_r1b_ch_ready", 64'(a.ch_ready_o), 64'b1000);
    chk("s4_r1b_data", a.data_o, 64'hD1);
    chk("s4_r1b_last", 64'(a.last_o), 64'd1);
    tick(); a.ch_valid_i = '0; a.ch_last_i = '0;
    #1 chk("s4_end_busy", 64'(a.busy_o), 64'd0);
    chk("s4_end_rr", 64'(rr_a), 64'd0);

    // Enable dropped on beat 2 of a five-beat ch1 burst
    a.ch_valid_i = 4'b0010; a.ch_data_i[1] = 64'hE1;
    #1;
    tick();
    chk("s5_b1_id", 64'(a.id_o), 64'd1);
    chk("s5_b1_valid", 64'(a.valid_o), 64'd1);
    for (int bt = 2; bt <= 5; bt++) begin
      tick();
      a.ch_data_i[1] = 64'hE0 + 64'(bt);
      if (bt == 2) a.ch_en_i[1] = 1'b0;
      if (bt == 5) a.ch_last_i[1] = 1'b1;
      #1 chk("s5_beat_valid", 64'(a.valid_o), 64'd1);
      chk("s5_beat_id", 64'(a.id_o), 64'd1);
      chk("s5_beat_data", a.data_o, 64'hE0 + 64'(bt));
    end
    tick(); a.ch_last_i = '0;
    #1 chk("s5_end_valid", 64'(a.valid_o), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s5_excluded_busy", 64'(a.busy_o), 64'd0);
    end
    a.ch_valid_i = '0; a.ch_en_i = 4'b1111;
    #1 chk("s5_rr", 64'(rr_a), 64'd2);

    // Reset during beat 3 of a ch2 burst
    a.ch_valid_i = 4'b0100; a.ch_data_i[2] = 64'hF1;
    #1;
    tick();
    chk("s6_b1_id", 64'(a.id_o), 64'd2);
    tick();
    tick();
    chk("s6_b3_valid", 64'(a.valid_o), 64'd1);
    rst_ni = 1'b0;
    #1 chk("s6_rst_valid", 64'(a.valid_o), 64'd0);
    chk("s6_rst_busy", 64'(a.busy_o), 64'd0);
    chk("s6_rst_id", 64'(a.id_o), 64'd0);
    chk("s6_rst_ch_ready", 64'(a.ch_ready_o), 64'd0);
    chk("s6_rst_rr", 64'(rr_a), 64'd0);
    chk("s6_rst_state", 64'(st_a), 64'(Idle));
    tick();
    rst_ni = 1'b1;
    a.ch_valid_i = 4'b0101; a.ch_data_i[0] = 64'h60;
    #1 chk("s6_idle_valid", 64'(a.valid_o), 64'd0);
    tick();
    chk("s6_first_id", 64'(a.id_o), 64'd0);
    chk("s6_first_valid", 64'(a.valid_o), 64'd1);
    chk("s6_first_data", a.data_o, 64'h60);
    a.ch_valid_i = '0;

    // MaxHold=4: ch0 ten-beat burst interleaved with an open-ended ch2 burst
    beat = 1;
    b.ch_en_i = 4'b0101; b.ch_valid_i = 4'b0101; b.ch_last_i = '0;
    b.ch_data_i[0] = 64'h100 + 64'(beat); b.ch_data_i[2] = 64'hC2;
    #1;
    for (int c = 0; c < 23; c++) begin
      chk("s3_valid", 64'(b.valid_o), 64'(seq[c] >= 0));
      if (seq[c] >= 0) begin
        chk("s3_id", 64'(b.id_o), 64'(seq[c]));
        chk("s3_last", 64'(b.last_o), 64'(seq[c] == 0 && beat == 10));
        chk("s3_data", b.data_o, (seq[c] == 0) ? 64'h100 + 64'(beat) : 64'hC2);
      end
      if (seq[c] == 0) beat++;
      tick();
      b.ch_data_i[0] = 64'h100 + 64'(beat);
      b.ch_last_i[0] = (beat == 10);
      if (c == 22) b.ch_valid_i = '0;
      #1;
    end
    chk("s3_end_busy", 64'(b.busy_o), 64'd0);
    chk("s3_end_rr", 64'(rr_b), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/apbdma_downsizer_arbiter.md
# apbdma_downsizer_arbiter

Round-robin arbiter that shares one wide-to-narrow downsizer between several DMA channel read streams. It sits between the per-channel wide data FIFOs and the single downsizer instance that feeds the APB write side. Once a channel wins, it holds the grant for a whole burst, so the narrow beats of different channels never interleave inside a burst. The block tags every beat with the owning channel ID and bounds how long any one channel may hold the grant.

## Interface
- NumChannels, 4, number of requesting channels (≥2)
- DataWidth, 64, wide beat width in bits (multiple of 8)
- MaxHold, 16, maximum beats per grant before forced re-arbitration (≥1)
- IdWidth, derived, $clog2(NumChannels)
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- ch_en_i  in  NumChannels  per-channel enable from the register file
- ch_data_i  in  NumChannels×DataWidth  per-channel wide data
- ch_strb_i  in  NumChannels×DataWidth/8  per-channel byte strobes
- ch_last_i  in  NumChannels  last beat of the channel's burst
- ch_valid_i  in  NumChannels  per-channel valid
- ch_ready_o  out  NumChannels  per-channel ready
- data_o  out  DataWidth  to downsizer data_i
- strb_o  out  DataWidth/8  to downsizer strb_i
- last_o  out  1  last beat of the granted burst
- id_o  out  IdWidth  granted channel index
- valid_o  out  1  to downsizer valid_i
- ready_i  in  1  from downsizer ready_o
- busy_o  out  1  a grant is held

## Operation
- States: Idle and Locked.
- **Idle**
  - valid_o=0, ch_ready_o=0.
  - Candidates are channels with ch_valid_i & ch_en_i.
  - If any candidate exists, the winner is the first candidate at or after rr_ptr, wrapping modulo NumChannels.
  - Next cycle: grant_q=winner, hold_cnt=0, state=Locked.
- **Locked**
  - data_o, strb_o, last_o and valid_o pass through combinationally from channel grant_q.
  - ch_ready_o[grant_q]=ready_i. All other ch_ready_o are 0.
  - id_o=grant_q, busy_o=1.
- **Handshake:** valid_o & ready_i. On each handshake, hold_cnt increments.
- **Release:** on a handshake with last_o=1, or with hold_cnt==MaxHold-1:
  - state goes to Idle.
  - rr_ptr goes to (grant_q+1) mod NumChannels, wrapping from NumChannels-1 to 0.
  - On a forced release (MaxHold reached, no last), the channel keeps its place in the burst. It re-competes normally and its remaining beats continue under the same id_o.
- **ch_en_i dropped while Locked:** the grant is not revoked. The channel finishes to last or MaxHold, then is excluded from arbitration.
- **ch_valid_i of grant_q low while Locked:** the block stays Locked and waits. valid_o=0.
- Data stalls are not the arbiter's concern. The downsizer drops ready_i while draining, and the arbiter only forwards it.
- hold_cnt is $clog2(MaxHold+1) bits wide and never exceeds MaxHold-1.

## Timing
- Reset values:
  - state=Idle, rr_ptr=0, grant_q=0, hold_cnt=0.
  - valid_o=0, busy_o=0, id_o=0, ch_ready_o=0.
  - data_o, strb_o and last_o are don't-care while valid_o=0.
- Arbitration latency: 1 cycle from the first candidate valid to valid_o, plus 1 idle cycle between consecutive grants.
- Minimum turnaround: release handshake at cycle N, Idle at N+1, new grant valid at N+2.
- Beat latency while Locked: 0 cycles. The path is combinational; there is no registered data path.
- Simultaneous requests in the same cycle are resolved purely by rr_ptr.
- A channel raising valid in the same cycle another releases is considered in the following Idle cycle.
- Reset asserted mid-burst: all state clears immediately, outputs take reset values, and any partially sent burst is abandoned. Upstream is responsible for flushing.
- valid_o never depends on ready_i.
- Once valid_o is asserted, data_o is held stable until the handshake, provided the channel obeys the same rule.

## Structure
- Package apbdma_pkg:
  - arb_state_t enum {Idle, Locked}.
  - Shared helper for the ID-width calculation, so max(1, $clog2(n)) is used consistently.
- Sub-module apbdma_rr_pick:
  - Purely combinational.
  - Inputs: candidate vector and rr_ptr.
  - Outputs: winner index and any_valid.
  - Implemented as a rotate, then priority encode, then un-rotate.
  - Reused later by the channel descriptor scheduler.
- The top level holds the FSM, grant_q, rr_ptr, hold_cnt and the output mux.

## Test plan
- **Single channel:** ch1 enabled, 3 beats with last on beat 3, ready_i=1.
  - valid_o rises 1 cycle after ch_valid_i[1].
  - id_o=1 for 3 beats.
  - busy_o falls the cycle after beat 3.
  - rr_ptr becomes 2.
- **All 4 channels valid simultaneously from reset, 1-beat bursts each:**
  - Grant order is 0,1,2,3,0.
  - There is exactly one idle cycle between grants.
- **MaxHold=4, ch0 sends 10 beats with last on 10, ch2 also valid:**
  - Beat sequence is ch0×4, ch2's burst, ch0×4, ch2, ch0×2.
  - last_o=1 only on ch0 beat 10.
- **ready_i backpressure:** ready_i toggles 1-0-0-1 during a ch3 burst.
  - ch_ready_o[3] mirrors ready_i.
  - data_o is stable while stalled.
  - No other ch_ready_o is asserted.
- **ch_en_i[1] cleared mid-burst (beat 2 of 5):**
  - The burst completes to last.
  - Afterwards ch1 is never granted, even with ch_valid_i[1]=1.
- **rst_ni asserted during beat 3 of a ch2 burst:**
  - Outputs take reset values asynchronously.
  - After release, with ch0 and ch2 both valid, ch0 is granted first.
